// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result stage.
// Contents:
//   - ALU op encodings (3 bits)
//   - flags_t: architectural {N,Z,C,V} flag struct
//   - ARM condition-code constants
//   - commit_flags(): op-dependent rule for merging an entry's flags
//     into the committed flags
// The full buffered entry (result, dest, op, setf, nzcv) depends on the
// WIDTH/TAGW parameters of the stage, so its struct is declared inside
// alu_result_stage using the flags_t defined here.
package alu_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Arithmetic ops own all four flags; logic ops define N/Z and clear C/V;
  // PASS_B only updates N/Z. Unknown ops leave the committed flags alone.
  function automatic flags_t commit_flags(input logic [2:0] op,
                                          input flags_t   cur,
                                          input flags_t   ent);
    flags_t nxt;
    nxt = cur;
    case (op)
      ALU_ADD, ALU_SUB: nxt = ent;
      ALU_AND, ALU_OR, ALU_XOR: begin
        nxt.n = ent.n;
        nxt.z = ent.z;
        nxt.c = 1'b0;
        nxt.v = 1'b0;
      end
      ALU_PASS_B: begin
        nxt.n = ent.n;
        nxt.z = ent.z;
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// cond_eval: purely combinational ARM condition-code evaluator.
// Ports:
//   cond      - 4-bit ARM condition code
//   flags     - committed {N,Z,C,V}
//   cond_true - 1 when the condition holds for the given flags
// Code 1111 (NV) is treated the same as AL.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      COND_EQ: cond_true = flags.z;
      COND_NE: cond_true = !flags.z;
      COND_CS: cond_true = flags.c;
      COND_CC: cond_true = !flags.c;
      COND_MI: cond_true = flags.n;
      COND_PL: cond_true = !flags.n;
      COND_VS: cond_true = flags.v;
      COND_VC: cond_true = !flags.v;
      COND_HI: cond_true = flags.c && !flags.z;
      COND_LS: cond_true = !flags.c || flags.z;
      COND_GE: cond_true = (flags.n == flags.v);
      COND_LT: cond_true = (flags.n != flags.v);
      COND_GT: cond_true = !flags.z && (flags.n == flags.v);
      COND_LE: cond_true = flags.z || (flags.n != flags.v);
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result stage behind the ALU slices.
// Captures result/carry/op/tag through valid/ready into a head+skid
// buffer, commits NZCV on handoff of flag-setting entries and evaluates
// branch conditions against the committed flags.
// Ports:
//   clk, reset            - clock, async active-high reset
//   in_valid/in_ready     - upstream handshake (in_ready is registered)
//   in_result, in_cout, in_cmsb, in_op, in_setf, in_dest - ALU outputs
//   out_valid/out_ready   - downstream handshake for the head entry
//   out_result, out_dest  - head entry payload
//   out_zero              - head result is zero (CBZ/CBNZ)
//   flags                 - committed {N,Z,C,V}
//   cond, cond_true       - B.cond query against committed flags
//   flush                 - squash all entries except one handing off
// WIDTH must be a multiple of 4 and at least 8.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_cout,
  input  logic             in_cmsb,
  input  logic [2:0]       in_op,
  input  logic             in_setf,
  input  logic [TAGW-1:0]  in_dest,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_dest,
  output logic             out_zero,
  output logic [3:0]       flags,
  input  logic [3:0]       cond,
  output logic             cond_true,
  input  logic             flush
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAGW-1:0]  dest;
    logic [2:0]       op;
    logic             setf;
    flags_t           nzcv;
  } entry_t;

  entry_t head_q;
  entry_t skid_q;
  logic   head_valid;
  logic   skid_valid;
  flags_t flags_q;
  entry_t in_entry;
  logic   accept;
  logic   handoff;

  // Flags are computed once at capture so the handoff path only muxes.
  always_comb begin
    in_entry.result = in_result;
    in_entry.dest   = in_dest;
    in_entry.op     = in_op;
    in_entry.setf   = in_setf;
    in_entry.nzcv.n = in_result[WIDTH-1];
    in_entry.nzcv.z = (in_result == '0);
    in_entry.nzcv.c = in_cout;
    in_entry.nzcv.v = in_cout ^ in_cmsb;
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign handoff  = head_valid && out_ready;

  // The skid is only ever written while the head is stalled, so a skid
  // promotion never coincides with an accept (in_ready is low then).
  // Flush still lets a same-cycle handoff commit its flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      flags_q    <= '0;
    end else begin
      if (handoff && head_q.setf)
        flags_q <= commit_flags(head_q.op, flags_q, head_q.nzcv);

      if (flush) begin
        head_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (handoff) begin
        if (skid_valid) begin
          head_q     <= skid_q;
          skid_valid <= 1'b0;
        end else if (accept) begin
          head_q <= in_entry;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (accept) begin
        if (head_valid) begin
          skid_q     <= in_entry;
          skid_valid <= 1'b1;
        end else begin
          head_q     <= in_entry;
          head_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid  = head_valid;
  assign out_result = head_q.result;
  assign out_dest   = head_q.dest;
  assign out_zero   = (head_q.result == '0);
  assign flags      = flags_q;

  cond_eval u_cond_eval (
    .cond      (cond),
    .flags     (flags_q),
    .cond_true (cond_true)
  );

endmodule
